// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   ALU_WIDTH_DEF - default datapath width
//   alu_op_e      - 3-bit operation encodings
//   alu_state_e   - control state machine states
//   is_shift_op   - true for the multi-cycle shift operations
package alu_pkg;

    localparam int unsigned ALU_WIDTH_DEF = 16;

    typedef enum logic [2:0] {
        OP_ADD   = 3'b000,
        OP_AND   = 3'b001,
        OP_XOR   = 3'b010,
        OP_PASSA = 3'b011,
        OP_LSHF  = 3'b100,
        OP_RSHFL = 3'b101,
        OP_RSHFA = 3'b110,
        OP_PASSB = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } alu_state_e;

    function automatic logic is_shift_op(input alu_op_e op);
        return (op == OP_LSHF) || (op == OP_RSHFL) || (op == OP_RSHFA);
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle ALU operations.
// Ports:
//   op_i     - operation select
//   a_i      - first operand
//   b_i      - second operand
//   res_o_c  - combinational result; shift ops return a_i unchanged,
//              which is exactly the shift-by-zero result
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEF
) (
    input  alu_op_e            op_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic [WIDTH-1:0]   res_o_c
);

    // Single-cycle operation select; ADD wraps modulo 2^WIDTH.
    always_comb begin
        res_o_c = a_i;
        case (op_i)
            OP_ADD:   res_o_c = a_i + b_i;
            OP_AND:   res_o_c = a_i & b_i;
            OP_XOR:   res_o_c = a_i ^ b_i;
            OP_PASSA: res_o_c = a_i;
            OP_PASSB: res_o_c = b_i;
            default:  res_o_c = a_i;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with single-cycle logic ops and
// one-bit-per-cycle shifts.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   in_valid    - request present
//   in_ready    - request accepted this cycle (IDLE, or DONE and out_ready)
//   op, a, b    - operation and operands, captured at accept
//   out_valid   - result/nzp hold a completed result
//   out_ready   - consumer takes the result this cycle
//   result      - registered result (partial value while shifting)
//   nzp         - registered one-hot {N,Z,P} of the final result
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = ALU_WIDTH_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [2:0]         nzp
);

    localparam int unsigned SHW = $clog2(WIDTH);

    alu_state_e         state_q;
    alu_op_e            op_q;
    logic [SHW-1:0]     cnt_q;
    logic [WIDTH-1:0]   result_q;
    logic [2:0]         nzp_q;
    logic               out_valid_q;

    alu_op_e            op_in;
    logic [SHW-1:0]     shamt;
    logic               accept;
    logic [WIDTH-1:0]   core_res;
    logic [WIDTH-1:0]   shift_step;

    function automatic logic [2:0] nzp_of(input logic [WIDTH-1:0] r);
        if (r[WIDTH-1]) begin
            return 3'b100;
        end else if (r == '0) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    assign op_in    = alu_op_e'(op);
    assign shamt    = b[SHW-1:0];
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept   = in_valid && in_ready;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op_i    (op_in),
        .a_i     (a),
        .b_i     (b),
        .res_o_c (core_res)
    );

    // One-bit shift of the partial result; arithmetic shift keeps the
    // current MSB, which is the original A sign bit.
    always_comb begin
        shift_step = result_q;
        case (op_q)
            OP_LSHF:  shift_step = {result_q[WIDTH-2:0], 1'b0};
            OP_RSHFL: shift_step = {1'b0, result_q[WIDTH-1:1]};
            OP_RSHFA: shift_step = {result_q[WIDTH-1], result_q[WIDTH-1:1]};
            default:  shift_step = result_q;
        endcase
    end

    // Control FSM and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            cnt_q       <= '0;
            result_q    <= '0;
            nzp_q       <= 3'b010;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        op_q <= op_in;
                        if (is_shift_op(op_in) && (shamt != '0)) begin
                            // Start from the unshifted operand; nzp keeps its
                            // old value until the shift completes.
                            state_q     <= ST_SHIFT;
                            cnt_q       <= shamt;
                            result_q    <= a;
                            out_valid_q <= 1'b0;
                        end else begin
                            state_q     <= ST_DONE;
                            result_q    <= core_res;
                            nzp_q       <= nzp_of(core_res);
                            out_valid_q <= 1'b1;
                        end
                    end else if ((state_q == ST_DONE) && out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    result_q <= shift_step;
                    cnt_q    <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_q     <= ST_DONE;
                        nzp_q       <= nzp_of(shift_step);
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign result    = result_q;
    assign nzp       = nzp_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed, table-driven bench for alu_pipe (WIDTH 16 and 32).
module tb_alu_pipe;

    logic        clk;
    logic        rst_n;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [2:0]  nzp;

    logic        in_valid32;
    logic        in_ready32;
    logic [2:0]  op32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        out_valid32;
    logic        out_ready32;
    logic [31:0] result32;
    logic [2:0]  nzp32;

    int n_cmp;
    int n_err;

    alu_pipe #(.WIDTH(16)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .nzp       (nzp)
    );

    alu_pipe #(.WIDTH(32)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid32),
        .in_ready  (in_ready32),
        .op        (op32),
        .a         (a32),
        .b         (b32),
        .out_valid (out_valid32),
        .out_ready (out_ready32),
        .result    (result32),
        .nzp       (nzp32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_res;
        logic [2:0]  exp_nzp;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vec [NV];

    logic [15:0] partial [3];
    int          cyc;
    logic        seen;

    initial begin
        n_cmp = 0;
        n_err = 0;

        // op, a, b, result, nzp, cycles from accept to out_valid
        vec[0]  = '{3'b000, 16'h0001, 16'h0001, 16'h0002, 3'b001, 1};
        vec[1]  = '{3'b010, 16'h1000, 16'h0001, 16'h1001, 3'b001, 1};
        vec[2]  = '{3'b001, 16'h0002, 16'h0001, 16'h0000, 3'b010, 1};
        vec[3]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 3'b010, 1};
        vec[4]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 3'b100, 1};
        vec[5]  = '{3'b011, 16'h8123, 16'h1111, 16'h8123, 3'b100, 1};
        vec[6]  = '{3'b111, 16'h1234, 16'h00FF, 16'h00FF, 3'b001, 1};
        vec[7]  = '{3'b001, 16'hF0F0, 16'hFF00, 16'hF000, 3'b100, 1};
        vec[8]  = '{3'b010, 16'hAAAA, 16'hAAAA, 16'h0000, 3'b010, 1};
        vec[9]  = '{3'b110, 16'h8004, 16'h0002, 16'hE001, 3'b100, 3};
        vec[10] = '{3'b101, 16'h8004, 16'h0002, 16'h2001, 3'b001, 3};
        vec[11] = '{3'b100, 16'h0001, 16'h000F, 16'h8000, 3'b100, 16};
        vec[12] = '{3'b100, 16'h1234, 16'h0010, 16'h1234, 3'b001, 1};
        vec[13] = '{3'b110, 16'h7FFF, 16'h000F, 16'h0000, 3'b010, 16};
        vec[14] = '{3'b110, 16'hFFFF, 16'h0004, 16'hFFFF, 3'b100, 5};
        vec[15] = '{3'b100, 16'h00F0, 16'h0004, 16'h0F00, 3'b001, 5};
        vec[16] = '{3'b101, 16'h8000, 16'h0001, 16'h4000, 3'b001, 2};
        vec[17] = '{3'b000, 16'h1234, 16'h4321, 16'h5555, 3'b001, 1};

        partial[0] = 16'h8000;
        partial[1] = 16'h4000;
        partial[2] = 16'h2000;

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        op          = 3'b000;
        a           = '0;
        b           = '0;
        out_ready   = 1'b1;
        in_valid32  = 1'b0;
        op32        = 3'b000;
        a32         = '0;
        b32         = '0;
        out_ready32 = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_result",    32'(result),    32'h0);
        chk("rst_nzp",       32'(nzp),       32'h2);
        chk("rst_in_ready",  32'(in_ready),  32'h1);
        rst_n = 1'b1;
        tick();

        // Table-driven vectors, issued back-to-back while out_ready=1
        for (int i = 0; i < NV; i++) begin
            in_valid = 1'b1;
            op = vec[i].op;
            a  = vec[i].a;
            b  = vec[i].b;
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'h1);
            tick();
            in_valid = 1'b0;
            cyc = 1;
            while (!out_valid && cyc < 40) begin
                tick();
                cyc++;
            end
            chk($sformatf("v%0d_latency", i), 32'(cyc), 32'(vec[i].lat));
            chk($sformatf("v%0d_result", i), 32'(result), 32'(vec[i].exp_res));
            chk($sformatf("v%0d_nzp", i), 32'(nzp), 32'(vec[i].exp_nzp));
        end
        tick();
        chk("drain_out_valid", 32'(out_valid), 32'h0);

        // Hold in DONE with out_ready=0; a pending request waits, not lost
        out_ready = 1'b0;
        in_valid = 1'b1;
        op = 3'b000; a = 16'h0004; b = 16'h0003;
        tick();
        op = 3'b000; a = 16'h0001; b = 16'h0001;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("hold%0d_out_valid", j), 32'(out_valid), 32'h1);
            chk($sformatf("hold%0d_result", j), 32'(result), 32'h7);
            chk($sformatf("hold%0d_nzp", j), 32'(nzp), 32'h1);
            chk($sformatf("hold%0d_in_ready", j), 32'(in_ready), 32'h0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("hold_release_in_ready", 32'(in_ready), 32'h1);
        tick();
        in_valid = 1'b0;
        chk("hold_next_result", 32'(result), 32'h2);
        chk("hold_next_valid", 32'(out_valid), 32'h1);
        tick();
        chk("hold_idle_valid", 32'(out_valid), 32'h0);
        chk("hold_idle_ready", 32'(in_ready), 32'h1);

        // Requests during SHIFT are ignored, partial result visible
        in_valid = 1'b1;
        op = 3'b101; a = 16'h8000; b = 16'h0003;
        tick();
        op = 3'b010; a = 16'h00FF; b = 16'h0F0F;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("sh%0d_in_ready", j), 32'(in_ready), 32'h0);
            chk($sformatf("sh%0d_out_valid", j), 32'(out_valid), 32'h0);
            chk($sformatf("sh%0d_partial", j), 32'(result), 32'(partial[j]));
            tick();
        end
        chk("sh_done_valid",  32'(out_valid), 32'h1);
        chk("sh_done_result", 32'(result),    32'h1000);
        chk("sh_done_nzp",    32'(nzp),       32'h1);
        tick();
        in_valid = 1'b0;
        chk("sh_next_result", 32'(result), 32'h0FF0);
        chk("sh_next_valid",  32'(out_valid), 32'h1);
        tick();
        chk("sh_idle_valid", 32'(out_valid), 32'h0);

        // Reset during an in-flight shift
        in_valid = 1'b1;
        op = 3'b100; a = 16'h0001; b = 16'h0007;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'h0);
        chk("mid_rst_result",    32'(result),    32'h0);
        chk("mid_rst_nzp",       32'(nzp),       32'h2);
        chk("mid_rst_in_ready",  32'(in_ready),  32'h1);
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int j = 0; j < 12; j++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("mid_rst_no_output", 32'(seen), 32'h0);
        chk("mid_rst_result_after", 32'(result), 32'h0);

        // WIDTH=32 instance
        in_valid32 = 1'b1;
        op32 = 3'b000; a32 = 32'hFFFF_FFFF; b32 = 32'h1;
        tick();
        chk("w32_add_valid",  32'(out_valid32), 32'h1);
        chk("w32_add_result", result32, 32'h0);
        chk("w32_add_nzp",    32'(nzp32), 32'h2);
        op32 = 3'b100; a32 = 32'h1; b32 = 32'd31;
        tick();
        in_valid32 = 1'b0;
        cyc = 1;
        while (!out_valid32 && cyc < 60) begin
            tick();
            cyc++;
        end
        chk("w32_lshf_latency", 32'(cyc), 32'd32);
        chk("w32_lshf_result",  result32, 32'h8000_0000);
        chk("w32_lshf_nzp",     32'(nzp32), 32'h4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
